// File: rtl/nibble_serial_tx_if.sv
// Parallel-side handshake of the nibble link transmitter: one DATA_BITS-element
// array moves from producer (master) to transmitter (slave) per valid/ready beat.
interface nibble_serial_tx_if #(
    parameter int DATA_BITS = 4
);
    logic in_data [DATA_BITS];
    logic in_valid;
    logic in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/nibble_serial_tx.sv
// Nibble link transmitter: serializes one captured array per handshake as
// start bit, data elements (element 0 first), optional even parity, stop bit.
module nibble_serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    nibble_serial_tx_if.slave  in_if,
    output logic               tx_out,
    output logic               busy,
    output logic               done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          shadow_q [DATA_BITS];
    logic          shadow_d [DATA_BITS];
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          parity;

    always_comb begin
        parity = 1'b0;
        for (int unsigned i = 0; i < DATA_BITS; i++) begin
            parity = parity ^ shadow_q[i];
        end
    end

    // tx_d is the line level for the state being entered, so tx_out changes
    // on the same edge as the state register.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q == IDLE) begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (in_if.in_valid) begin
                shadow_d = in_if.in_data;
                state_d  = START;
                cnt_d    = '0;
                idx_d    = '0;
                tx_d     = 1'b0;
                busy_d   = 1'b1;
            end
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
            unique case (state_q)
                START: begin
                    state_d = DATA;
                    idx_d   = '0;
                    tx_d    = shadow_q[0];
                end
                DATA: begin
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + IW'(1);
                        tx_d  = shadow_q[idx_d];
                    end else if (PARITY_EN != 0) begin
                        state_d = PARITY;
                        tx_d    = parity;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
                STOP: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '{default: 1'b0};
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign in_if.in_ready = (state_q == IDLE);
    assign tx_out         = tx_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_nibble_serial_tx.sv
// Bench for nibble_serial_tx: four configurations driven in turn, accepted
// arrays queued as expected frames and checked cycle by cycle by a monitor.
module tb_nibble_serial_tx;
    localparam int NDUT = 4;
    localparam int CPB_T [NDUT] = '{4, 4, 7, 2};
    localparam int PE_T  [NDUT] = '{0, 1, 0, 1};
    localparam int unsigned CYC_LIMIT = 40000;

    typedef struct {
        int          g;
        logic [3:0]  d;
        int unsigned start;
    } exp_t;

    logic        clk;
    int unsigned cyc = 0;
    logic [3:0]  vld;
    logic [3:0]  rstn;
    logic [3:0]  dat [NDUT];
    logic        rdy_w  [NDUT];
    logic        tx_w   [NDUT];
    logic        busy_w [NDUT];
    logic        done_w [NDUT];

    exp_t exp_q [$];
    int   checks = 0;
    int   failures = 0;
    int   drv_timeouts = 0;
    bit   drv_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        nibble_serial_tx_if #(.DATA_BITS(4)) ifc ();
        assign ifc.in_valid = vld[g];
        for (genvar b = 0; b < 4; b++) begin : gen_bit
            assign ifc.in_data[b] = dat[g][b];
        end
        assign rdy_w[g] = ifc.in_ready;
        nibble_serial_tx #(
            .CLKS_PER_BIT(CPB_T[g]),
            .DATA_BITS   (4),
            .PARITY_EN   (PE_T[g])
        ) dut (
            .clk   (clk),
            .rst_n (rstn[g]),
            .in_if (ifc),
            .tx_out(tx_w[g]),
            .busy  (busy_w[g]),
            .done  (done_w[g])
        );
    end

    function automatic int frame_len(input int g);
        return (4 + 2 + PE_T[g]) * CPB_T[g];
    endfunction

    // Line level k cycles into a frame, straight from the framing rules.
    function automatic logic exp_line(input int g, input logic [3:0] d, input int k);
        int p;
        p = k / CPB_T[g];
        if (p == 0) return 1'b0;
        if (p <= 4) return d[p-1];
        if (PE_T[g] != 0 && p == 5) return ^d;
        return 1'b1;
    endfunction

    function automatic void chk(input int g, input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL dut%0d %s at cycle %0d: got %0h expected %0h", g, nm, cyc, act, req);
        end
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int g, input logic [3:0] d, input bit keep);
        bit ok;
        ok = 0;
        vld[g] = 1'b1;
        dat[g] = d;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (rdy_w[g]) begin
                exp_q.push_back('{g, d, cyc + 1});
                ok = 1;
            end
            step(1);
        end
        if (!ok) drv_timeouts++;
        if (!keep) vld[g] = 1'b0;
    endtask

    // Driver: configurations are exercised one after another.
    initial begin
        vld  = '0;
        rstn = '0;
        for (int g = 0; g < NDUT; g++) dat[g] = '0;
        step(3);
        rstn = '1;
        step(2);
        for (int g = 0; g < NDUT; g++) begin
            int f;
            logic [3:0] d;
            f = frame_len(g);
            d = (g == 0) ? 4'b1101 : (g == 1) ? 4'b0111 : 4'($urandom);
            send(g, d, 0);
            for (int i = 0; i < f - 4; i++) begin
                vld[g] = 1'b1;
                dat[g] = 4'($urandom);
                step(1);
            end
            vld[g] = 1'b0;
            step(f + 2);
            send(g, 4'h0, 1);
            send(g, 4'hF, 0);
            step(f + 2);
            for (int n = 0; n < 12; n++) begin
                bit keep;
                keep = (n != 11) && ($urandom_range(0, 1) == 1);
                send(g, 4'($urandom), keep);
                if (!keep) step($urandom_range(0, 3));
            end
            step(f + 2);
            send(g, 4'($urandom), 0);
            step(CPB_T[g] + 2);
            rstn[g] = 1'b0;
            step(3);
            rstn[g] = 1'b1;
            step(2);
            send(g, 4'b1001, 0);
            step(f + 3);
        end
        drv_done = 1;
    end

    // Monitor: every DUT's status {tx_out, busy, done, in_ready} every cycle.
    bit         in_frame [NDUT];
    int         kk       [NDUT];
    logic [3:0] cur      [NDUT];

    initial begin
        for (int g = 0; g < NDUT; g++) begin
            in_frame[g] = 0;
            kk[g] = 0;
            cur[g] = '0;
        end
        while (!drv_done && cyc < CYC_LIMIT) begin
            @(negedge clk);
            for (int g = 0; g < NDUT; g++) begin
                int act;
                act = {28'd0, tx_w[g], busy_w[g], done_w[g], rdy_w[g]};
                if (rstn[g] !== 1'b1) begin
                    in_frame[g] = 0;
                    chk(g, "reset_status", act, 4'b1001);
                    continue;
                end
                if (!in_frame[g] && exp_q.size() > 0 && exp_q[0].g == g) begin
                    if (exp_q[0].start < cyc) begin
                        chk(g, "frame_start", int'(cyc), int'(exp_q[0].start));
                        void'(exp_q.pop_front());
                    end else if (exp_q[0].start == cyc) begin
                        cur[g] = exp_q[0].d;
                        void'(exp_q.pop_front());
                        in_frame[g] = 1;
                        kk[g] = 0;
                    end
                end
                if (in_frame[g]) begin
                    if (kk[g] < frame_len(g)) begin
                        chk(g, "frame_status", act,
                            {28'd0, exp_line(g, cur[g], kk[g]), 3'b100});
                        kk[g]++;
                    end else begin
                        chk(g, "done_status", act, 4'b1011);
                        in_frame[g] = 0;
                    end
                end else begin
                    chk(g, "idle_status", act, 4'b1001);
                end
            end
        end
        chk(-1, "driver_finished", int'(drv_done), 1);
        chk(-1, "handshake_timeouts", drv_timeouts, 0);
        chk(-1, "frames_outstanding", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
